// File: rtl/risky_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the risky memory bus.
// One strobed access at a time, per-region wait states, registered ack/err/rdata.
module risky_bus_arbiter #(
    parameter int unsigned ROM_WAIT  = 1,
    parameter int unsigned RAM_WAIT  = 0,
    parameter int unsigned MMIO_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_oe,
    output logic        mem_we,
    output logic        sel_rom,
    output logic        sel_ram,
    output logic        sel_mmio
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK, ERR} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    state_t   state;
    logic     last_gnt;
    logic     gnt_id;
    logic     lat_we;
    logic [3:0] cnt;

    logic     any_req;
    logic     gnt_nxt;
    bus_req_t req;
    logic     mapped;
    logic [2:0] sel_nxt;
    logic [3:0] wait_nxt;

    always_comb begin
        any_req = m0_req | m1_req;
        // Round robin only matters on contention; a lone requester always wins.
        if (m0_req && m1_req) gnt_nxt = ~last_gnt;
        else                  gnt_nxt = m1_req & ~m0_req;
        req = gnt_nxt ? '{we: m1_we, addr: m1_addr, wdata: m1_wdata}
                      : '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
        mapped   = 1'b1;
        sel_nxt  = 3'b000;
        wait_nxt = 4'd0;
        case (req.addr[31:26])
            6'd0:    begin sel_nxt = 3'b001; wait_nxt = 4'(ROM_WAIT);  end
            6'd1:    begin sel_nxt = 3'b010; wait_nxt = 4'(RAM_WAIT);  end
            6'd2:    begin sel_nxt = 3'b100; wait_nxt = 4'(MMIO_WAIT); end
            default: mapped = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            gnt_id    <= 1'b0;
            lat_we    <= 1'b0;
            cnt       <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            sel_rom   <= 1'b0;
            sel_ram   <= 1'b0;
            sel_mmio  <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    gnt_id    <= gnt_nxt;
                    last_gnt  <= gnt_nxt;
                    mem_addr  <= req.addr;
                    mem_wdata <= req.wdata;
                    lat_we    <= req.we;
                    if (mapped) begin
                        state    <= ACCESS;
                        cnt      <= wait_nxt;
                        sel_rom  <= sel_nxt[0];
                        sel_ram  <= sel_nxt[1];
                        sel_mmio <= sel_nxt[2];
                        mem_oe   <= ~req.we;
                        mem_we   <= req.we && (wait_nxt == 4'd0);
                    end else begin
                        state <= ERR;
                        if (gnt_nxt) begin m1_ack <= 1'b1; m1_err <= 1'b1; end
                        else         begin m0_ack <= 1'b1; m0_err <= 1'b1; end
                    end
                end
                ACCESS: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                    // Strobe is registered, so raise it on entry to the last cycle.
                    mem_we <= lat_we && (cnt == 4'd1);
                end else begin
                    state    <= ACK;
                    sel_rom  <= 1'b0;
                    sel_ram  <= 1'b0;
                    sel_mmio <= 1'b0;
                    mem_oe   <= 1'b0;
                    if (gnt_id) m1_ack <= 1'b1;
                    else        m0_ack <= 1'b1;
                    if (!lat_we) begin
                        if (gnt_id) m1_rdata <= mem_rdata;
                        else        m0_rdata <= mem_rdata;
                    end
                end
                ACK:     state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/risky_bus_arbiter.md
# risky_bus_arbiter

Two-master arbiter and sequencer for the risky memory bus. It shares the single ROM/RAM/MMIO port between the CPU (master 0) and a secondary requester such as a loader or DMA engine (master 1). It decodes the region from the address, applies a per-region wait-state count, drives one strobed access at a time, and returns a registered read-data/acknowledge pulse to the winning master. The block sits between the masters and the memory/MMIO models, and replaces direct CPU-to-bus wiring.

## Interface
- ROM_WAIT, 1, extra access cycles for region 0 (addr[31:26]==0), range 0..15
- RAM_WAIT, 0, extra access cycles for region 1
- MMIO_WAIT, 2, extra access cycles for region 2
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- m0_req, m1_req  in  1  request; held until matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr, m1_addr  in  32  word address
- m0_wdata, m1_wdata  in  32  write data
- m0_rdata, m1_rdata  out  32  registered read data, valid in ack cycle
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  one-cycle pulse with ack on unmapped address
- mem_addr  out  32  latched address of granted transaction
- mem_wdata  out  32  latched write data
- mem_rdata  in  32  read data from selected region
- mem_oe  out  1  read enable
- mem_we  out  1  write strobe
- sel_rom, sel_ram, sel_mmio  out  1  one-hot region select, high only during ACCESS

## Operation
- States: IDLE, ACCESS, ACK, ERR.
- IDLE: if any req is high, grant one master. Latch that master's addr, we, wdata and grant id. Decode the region from addr[31:26]:
  - 0 → ROM, 1 → RAM, 2 → MMIO.
  - Other values → ERR.
  - Mapped regions → ACCESS, with the 4-bit counter loaded with that region's WAIT value.
- Arbitration: round-robin, applied only when both req are high. The master not granted last time wins. After reset, m0 has priority. A lone requester always wins, so the same master can win back-to-back.
- ACCESS:
  - Drive mem_addr, mem_wdata and the matching sel_*.
  - mem_oe is held high for every ACCESS cycle of a read.
  - mem_we is high only in the final ACCESS cycle (counter==0) of a write. Exactly one write strobe per write.
  - If counter≠0, decrement it. If counter==0, capture mem_rdata (reads) into the granted master's rdata register, then go to ACK.
- ACK: the granted master's ack is high for one cycle, then IDLE. rdata is held until that master's next ack. Writes leave rdata unchanged.
- ERR: the granted master's ack and err are both high for one cycle, then IDLE. No oe, we or sel is asserted for the whole transaction.
- The non-granted master's ack/err are never asserted.
- Masters must drop req, or present a new transaction, by the cycle after ack. A req still high in IDLE is a new request.
- Changing we, addr or wdata while req is high and not yet acked is undefined. The latched copy is used.

## Timing
- Reset values:
  - State IDLE, priority to m0, counter 0.
  - mem_oe, mem_we, all sel_*, ack, err = 0.
  - mem_addr, mem_wdata, m0_rdata, m1_rdata = 0.
- Reset during ACCESS/ACK/ERR aborts the transaction. No ack is issued and no further strobe is driven.
- Request sampled in IDLE at cycle 0:
  - ACCESS occupies cycles 1..1+W.
  - ack is in cycle 2+W.
  - Latency is 2+W cycles.
- Unmapped address: ERR in cycle 1, ack+err in cycle 1, back to IDLE in cycle 2.
- Minimum bus turnaround: one IDLE cycle between transactions. Throughput is one access per 3+W cycles.
- mem_we is registered and never asserts in the same cycle as ack.

## Test plan
- Reset, m0 read of 0x0400_0010 (RAM, W=0), mem_rdata=0xDEADBEEF:
  - Required: sel_ram and mem_oe high in cycle 1 only, mem_we never high.
  - Required: m0_ack in cycle 2 with m0_rdata=0xDEADBEEF.
- m1 write 0x0800_0002 (MMIO, W=2), wdata=0x41:
  - Required: sel_mmio high cycles 1–3, mem_we high in cycle 3 only, mem_wdata=0x41.
  - Required: m1_ack in cycle 4, m1_rdata unchanged.
- Both req high right after reset, each for two back-to-back reads:
  - Required: grant order m0, m1, m0, m1.
  - Required: m1 alone back-to-back is granted consecutively.
- m0 read of 0x0C00_0000:
  - Required: m0_ack=m0_err=1 in cycle 1, mem_oe/mem_we/sel_* stay 0, m0_rdata unchanged.
- ROM read (W=1) with rst pulsed in cycle 1:
  - Required: all outputs zero in the cycle after reset, no m0_ack.
  - Required: the next both-req arbitration grants m0 first.
